lisnoc_router_output_arb: RTL and testbench
===========================================

# lisnoc_router_output_arb

Per-output-port switch arbiter for the lisnoc router. It receives direction requests and flits from every input port's route stage and grants one input at a time with round-robin fairness. The grant is held for the whole wormhole packet, from header to last flit, and the granted flit goes into a one-entry registered output stage that drives the output link. One instance sits behind each output port and each virtual channel, between the input ports' route stages and the output link.

## Interface
Parameters:
- flit_data_width, 32, data bits per flit
- flit_type_width, 2, type bits per flit; flit_width = data + type
- ports, 5, number of input ports competing for this output

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- request  in  ports  bit i: input i requests this output; held until read
- flit_i  in  flit_width*ports  flit of input i at bits [(i+1)*flit_width-1 : i*flit_width]
- read  out  ports  one-hot acknowledge; the flit of input i is taken this cycle
- out_flit  out  flit_width  registered output flit
- out_valid  out  1  out_flit is valid
- out_ready  in  1  downstream accepts out_flit this cycle

## Operation
- Flit type sits in the upper flit_type_width bits. Types come from lisnoc_def.vh: PAYLOAD=00, HEADER=01, LAST=10, SINGLE=11.
- can_accept = !out_valid || out_ready.
- Transfer on input i = read[i]. At most one read bit is set per cycle. read is combinational from request, state and can_accept.
- Arbiter state machine:
  - IDLE: if can_accept and request != 0, grant g = the first requester after last_grant, searching cyclically (round-robin). Set read[g]=1.
    - If the granted flit is SINGLE: stay IDLE and set last_grant=g.
    - If the granted flit is HEADER, PAYLOAD or LAST: go to LOCKED with owner=g and set last_grant=g.
  - LOCKED: read[owner] = request[owner] && can_accept. All other requests are ignored.
    - Transfer of a LAST or SINGLE flit: go to IDLE.
    - Any other type: stay LOCKED. A HEADER arriving while LOCKED is treated as payload and raises no error.
- Output stage: on a transfer, out_flit ← flit of the granted input and out_valid ← 1. Otherwise, if out_ready, out_valid ← 0.
- out_flit holds its value while out_valid && !out_ready.

## Timing
- Reset: state=IDLE, last_grant=ports-1 (so input 0 has first priority), out_valid=0, out_flit=0, read=0.
- Latency: a flit read in cycle N appears on out_flit/out_valid in cycle N+1.
- Throughput: one flit per cycle while out_ready=1 and the owner keeps requesting. No bubble between packets: the header of the next packet may be granted in the cycle after LAST is read.
- Owner drops request mid-packet: no read occurs, the lock is kept, and out_valid falls after the current flit drains.
- Backpressure (out_valid && !out_ready): read=0, with no state, owner or pointer change.
- Simultaneous events: drain and refill in the same cycle are allowed (out_ready=1 plus a transfer keeps out_valid=1 with the new flit).
- Reset asserted mid-packet: lock dropped, out_valid=0 next cycle, and the partially sent flit in the output register is discarded.

## Structure
- Flit-type constants come from the shared lisnoc_def.vh include, closed with lisnoc_undef.vh. No new defines are added.
- Sub-module lisnoc_arb_rr: combinational round-robin arbiter, parameter N.
  - Inputs: req[N], last[N] (one-hot).
  - Output: gnt[N] (one-hot).
  - Implemented as a doubled-vector priority search.
- Top level contains the IDLE/LOCKED state machine, the owner and last_grant registers, the flit mux and the output register.

## Test plan
- Single flit: after reset, request=00100 with input 2 carrying SINGLE 0x3_DEADBEEF → read=00100 in cycle 0; out_valid=1, out_flit=0x3_DEADBEEF in cycle 1; state stays IDLE.
- Fairness: inputs 0 and 3 both stream SINGLE flits with out_ready=1 → grant order 0,3,0,3…; each input is read every 2 cycles.
- Packet lock: input 1 sends HEADER, PAYLOAD, LAST while input 4 requests continuously from cycle 0 → read=00010 for 3 consecutive cycles, then read=10000 in cycle 3.
- Backpressure: out_ready=0 for 4 cycles while out_valid=1 → read=0 and out_flit unchanged; out_ready=1 → transfers resume with no flit lost or duplicated.
- Owner bubble: input 1 is LOCKED and drops request for 2 cycles after HEADER while input 0 requests → read stays 0 during the gap; input 0 is granted only after input 1's LAST.
- Reset mid-packet: rst pulsed after the PAYLOAD read → out_valid=0 and state IDLE next cycle; a new SINGLE from input 0 is granted first.

Source files
------------

// File: rtl/lisnoc_router_output_arb_pkg.sv
// Shared types for the lisnoc output-port arbiter: flit type codes and arbiter states.
package lisnoc_router_output_arb_pkg;

    typedef enum logic [1:0] {
        FLIT_PAYLOAD = 2'b00,
        FLIT_HEADER  = 2'b01,
        FLIT_LAST    = 2'b10,
        FLIT_SINGLE  = 2'b11
    } flit_type_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic logic ends_packet(input logic [1:0] flit_type);
        return (flit_type == FLIT_LAST) || (flit_type == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/lisnoc_router_output_arb_rr.sv
// Combinational round-robin arbiter: grants the first requester after the one-hot
// last grant, searching a doubled request vector so the wrap-around is implicit.
module lisnoc_arb_rr #(
    parameter int N = 5
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    output logic [N-1:0] gnt
);

    logic [2*N-1:0] req_dbl;
    logic           found;

    always_comb begin
        req_dbl = {req, req};
        gnt     = '0;
        found   = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (last[j]) begin
                for (int k = 1; k <= N; k++) begin
                    if (!found && req_dbl[j+k]) begin
                        gnt[(j+k)%N] = 1'b1;
                        found        = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/lisnoc_router_output_arb.sv
// Per-output switch arbiter: round-robin grant held for a whole wormhole packet,
// feeding a one-entry registered output stage.
module lisnoc_router_output_arb
    import lisnoc_router_output_arb_pkg::*;
#(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int ports           = 5
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [ports-1:0]                                  request,
    input  logic [(flit_data_width+flit_type_width)*ports-1:0] flit_i,
    output logic [ports-1:0]                                  read,
    output logic [flit_data_width+flit_type_width-1:0]        out_flit,
    output logic                                              out_valid,
    input  logic                                              out_ready
);

    localparam int flit_width = flit_data_width + flit_type_width;

    arb_state_t              state, state_nxt;
    logic [ports-1:0]        owner, owner_nxt;
    logic [ports-1:0]        last_grant, last_grant_nxt;
    logic [ports-1:0]        gnt;
    logic                    can_accept;
    logic                    transfer;
    logic [flit_width-1:0]   sel_flit;
    logic [1:0]              sel_type;

    lisnoc_arb_rr #(.N(ports)) u_arb_rr (
        .req  (request),
        .last (last_grant),
        .gnt  (gnt)
    );

    always_comb begin
        can_accept = !out_valid || out_ready;
        read       = '0;
        if (!rst && can_accept) begin
            read = (state == ARB_LOCKED) ? (owner & request) : gnt;
        end
        transfer = |read;

        sel_flit = '0;
        for (int i = 0; i < ports; i++) begin
            if (read[i]) begin
                sel_flit = sel_flit | flit_i[i*flit_width +: flit_width];
            end
        end
        // Type codes live in the low bits of the type field at the top of the flit.
        sel_type = sel_flit[flit_data_width +: 2];
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        case (state)
            ARB_IDLE: begin
                if (transfer) begin
                    last_grant_nxt = read;
                    if (sel_type != FLIT_SINGLE) begin
                        state_nxt = ARB_LOCKED;
                        owner_nxt = read;
                    end
                end
            end
            ARB_LOCKED: begin
                // A HEADER seen here is just another body flit of the owner.
                if (transfer && ends_packet(sel_type)) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            last_grant <= {1'b1, {(ports-1){1'b0}}};
            out_valid  <= 1'b0;
            out_flit   <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            if (transfer) begin
                out_flit  <= sel_flit;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lisnoc_router_output_arb.sv
// Bench for lisnoc_router_output_arb: directed vector table followed by random traffic
// compared against an integer-level reference model.
module tb_lisnoc_router_output_arb;

    localparam int FW = 34;
    localparam int NP = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     request = '0;
    logic [FW*NP-1:0]  flit_i = '0;
    logic [NP-1:0]     read;
    logic [FW-1:0]     out_flit;
    logic              out_valid;
    logic              out_ready = 1'b1;

    int n_vec  = 0;
    int n_miss = 0;

    lisnoc_router_output_arb #(
        .flit_data_width (32),
        .flit_type_width (2),
        .ports           (NP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .request   (request),
        .flit_i    (flit_i),
        .read      (read),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic [NP-1:0]    req;
        logic             ready;
        logic [FW*NP-1:0] flits;
        logic [NP-1:0]    exp_read;
        logic             exp_valid;
        logic [FW-1:0]    exp_flit;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [FW*NP-1:0] fl(input logic [FW-1:0] f0, f1, f2, f3, f4);
        return {f4, f3, f2, f1, f0};
    endfunction

    task automatic add(input logic r, input logic [NP-1:0] rq, input logic rdy,
                       input logic [FW*NP-1:0] f, input logic [NP-1:0] er,
                       input logic ev, input logic [FW-1:0] ef);
        vec_t v;
        v.rst = r; v.req = rq; v.ready = rdy; v.flits = f;
        v.exp_read = er; v.exp_valid = ev; v.exp_flit = ef;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at vector %0d: got %h, expected %h", nm, n_vec, act, exp);
        end
    endtask

    // Reference model state: integer owner/pointer, output register contents.
    bit            m_locked;
    int            m_owner;
    int            m_last;
    bit            m_ov;
    logic [FW-1:0] m_of;

    function automatic logic [NP-1:0] m_read();
        logic [NP-1:0] r = '0;
        if (rst || (m_ov && !out_ready)) return r;
        if (m_locked) begin
            if (request[m_owner]) r[m_owner] = 1'b1;
            return r;
        end
        for (int k = 1; k <= NP; k++) begin
            int i;
            i = (m_last + k) % NP;
            if (request[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic m_clock(input logic [NP-1:0] r);
        int g;
        logic [FW-1:0] f;
        logic [1:0] t;
        if (rst) begin
            m_locked = 0; m_owner = 0; m_last = NP - 1; m_ov = 0; m_of = '0;
            return;
        end
        if (r == '0) begin
            if (out_ready) m_ov = 0;
            return;
        end
        g = 0;
        for (int i = 0; i < NP; i++) if (r[i]) g = i;
        f = flit_i[g*FW +: FW];
        t = f[FW-1 -: 2];
        m_of = f;
        m_ov = 1;
        if (!m_locked) begin
            m_last = g;
            if (t != 2'b11) begin
                m_locked = 1;
                m_owner = g;
            end
        end else if (t == 2'b10 || t == 2'b11) begin
            m_locked = 0;
        end
    endtask

    initial begin
        logic [FW*NP-1:0] z;
        logic [NP-1:0]    er;
        z = '0;

        // Reset, then a lone SINGLE flit from input 2.
        add(1, 5'b00000, 1, z, 5'b00000, 0, 34'h0);
        add(0, 5'b00100, 1, fl(0, 0, 34'h3_DEADBEEF, 0, 0), 5'b00100, 1, 34'h3_DEADBEEF);
        add(0, 5'b00000, 1, z, 5'b00000, 0, 34'h3_DEADBEEF);
        // Fairness between inputs 0 and 3.
        add(1, 5'b00000, 1, z, 5'b00000, 0, 34'h0);
        for (int n = 0; n < 2; n++) begin
            add(0, 5'b01001, 1, fl(34'h3_000000A0, 0, 0, 34'h3_000000A3, 0), 5'b00001, 1, 34'h3_000000A0);
            add(0, 5'b01001, 1, fl(34'h3_000000A0, 0, 0, 34'h3_000000A3, 0), 5'b01000, 1, 34'h3_000000A3);
        end
        // Packet lock: input 1 holds the output for HEADER/PAYLOAD/LAST, then input 4.
        add(1, 5'b00000, 1, z, 5'b00000, 0, 34'h0);
        add(0, 5'b10010, 1, fl(0, 34'h1_00000011, 0, 0, 34'h3_00000044), 5'b00010, 1, 34'h1_00000011);
        add(0, 5'b10010, 1, fl(0, 34'h0_00000012, 0, 0, 34'h3_00000044), 5'b00010, 1, 34'h0_00000012);
        add(0, 5'b10010, 1, fl(0, 34'h2_00000013, 0, 0, 34'h3_00000044), 5'b00010, 1, 34'h2_00000013);
        add(0, 5'b10010, 1, fl(0, 34'h1_00000014, 0, 0, 34'h3_00000044), 5'b10000, 1, 34'h3_00000044);
        // Backpressure for 4 cycles, then resume.
        for (int n = 0; n < 4; n++)
            add(0, 5'b00001, 0, fl(34'h3_00000050, 0, 0, 0, 0), 5'b00000, 1, 34'h3_00000044);
        add(0, 5'b00001, 1, fl(34'h3_00000050, 0, 0, 0, 0), 5'b00001, 1, 34'h3_00000050);
        add(0, 5'b00000, 1, z, 5'b00000, 0, 34'h3_00000050);
        // Owner bubble: input 1 locked but silent for 2 cycles while input 0 waits.
        add(1, 5'b00000, 1, z, 5'b00000, 0, 34'h0);
        add(0, 5'b00010, 1, fl(34'h3_00000060, 34'h1_00000021, 0, 0, 0), 5'b00010, 1, 34'h1_00000021);
        add(0, 5'b00001, 1, fl(34'h3_00000060, 34'h1_00000021, 0, 0, 0), 5'b00000, 0, 34'h1_00000021);
        add(0, 5'b00001, 1, fl(34'h3_00000060, 34'h1_00000021, 0, 0, 0), 5'b00000, 0, 34'h1_00000021);
        add(0, 5'b00011, 1, fl(34'h3_00000060, 34'h2_00000022, 0, 0, 0), 5'b00010, 1, 34'h2_00000022);
        add(0, 5'b00001, 1, fl(34'h3_00000060, 0, 0, 0, 0), 5'b00001, 1, 34'h3_00000060);
        // Reset mid-packet, then input 0 wins from a fresh pointer.
        add(0, 5'b00010, 1, fl(0, 34'h1_00000031, 0, 0, 0), 5'b00010, 1, 34'h1_00000031);
        add(0, 5'b00010, 1, fl(0, 34'h0_00000032, 0, 0, 0), 5'b00010, 1, 34'h0_00000032);
        add(1, 5'b00011, 1, fl(34'h3_00000070, 34'h0_00000033, 0, 0, 0), 5'b00000, 0, 34'h0);
        add(0, 5'b00011, 1, fl(34'h3_00000070, 34'h0_00000033, 0, 0, 0), 5'b00001, 1, 34'h3_00000070);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; request = tbl[i].req; out_ready = tbl[i].ready; flit_i = tbl[i].flits;
            #1;
            chk("dir_read", FW'(read), FW'(tbl[i].exp_read));
            @(posedge clk);
            #1;
            chk("dir_valid", FW'(out_valid), FW'(tbl[i].exp_valid));
            chk("dir_flit", out_flit, tbl[i].exp_flit);
            n_vec++;
        end

        // Random traffic against the reference model, starting from reset.
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_clock(5'b00000);
        @(posedge clk);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 59) == 0);
            request = NP'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NP; i++)
                flit_i[i*FW +: FW] = {2'($urandom), 32'($urandom)};
            #1;
            er = m_read();
            chk("rnd_read", FW'(read), FW'(er));
            m_clock(er);
            @(posedge clk);
            #1;
            chk("rnd_valid", FW'(out_valid), FW'(m_ov));
            chk("rnd_flit", out_flit, m_of);
            n_vec++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
